chimera_cluster_pwr_seq: RTL and testbench

Per-cluster power sequencer in the cluster domain. It sits between the top-level config registers and each cluster's clock gate, reset, and AXI isolation. On a software enable or disable request, it orders the clock-enable, reset, and AXI-isolate steps so that a cluster never sees or issues traffic while unclocked or held in reset. It is instantiated once in the SoC top with one independent FSM per cluster. Its behaviour depends on the config's IsolateClusters field.

---
 rtl/chimera_cluster_pwr_seq.sv | 154 +++++++++++++++
 tb/tb_chimera_cluster_pwr_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/chimera_cluster_pwr_seq.sv
// Per-cluster power sequencer: orders clock enable, reset release and AXI isolation on enable/disable.
// Optional isolation-ack timeout is enabled by defining CHIMERA_PWR_SEQ_TIMEOUT_EN.
module chimera_cluster_pwr_seq #(
  parameter int unsigned NumClusters     = 5,
  parameter bit          IsolateClusters = 1'b1,
  parameter int unsigned RstCycles       = 4,
  parameter int unsigned TimeoutCycles   = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumClusters-1:0] en_req_i,
  input  logic [NumClusters-1:0] err_clr_i,
  input  logic [NumClusters-1:0] isolated_i,
  output logic [NumClusters-1:0] clk_en_o,
  output logic [NumClusters-1:0] cluster_rst_o,
  output logic [NumClusters-1:0] isolate_o,
  output logic [NumClusters-1:0] pwr_on_o,
  output logic [NumClusters-1:0] busy_o,
  output logic [NumClusters-1:0] err_o
);

  localparam int unsigned CntWidth = 16;
  localparam logic [CntWidth-1:0] RstLast = CntWidth'(RstCycles - 1);
  localparam logic [CntWidth-1:0] CntMax  = '1;
`ifdef CHIMERA_PWR_SEQ_TIMEOUT_EN
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);
`else
  localparam int unsigned unusedTimeoutCycles = TimeoutCycles;
`endif

  typedef enum logic [2:0] {
    Off   = 3'd0,
    ClkEn = 3'd1,
    Deiso = 3'd2,
    On    = 3'd3,
    Iso   = 3'd4,
    RstOn = 3'd5
  } state_t;

  state_t                state     [NumClusters];
  state_t                stateNext [NumClusters];
  logic [CntWidth-1:0]   cnt       [NumClusters];
  logic [CntWidth-1:0]   cntNext   [NumClusters];

  logic [NumClusters-1:0] clkEnQ, clkEnD;
  logic [NumClusters-1:0] rstQ, rstD;
  logic [NumClusters-1:0] isoQ, isoD;
  logic [NumClusters-1:0] pwrOnQ, pwrOnD;
  logic [NumClusters-1:0] busyQ, busyD;
  logic [NumClusters-1:0] errQ, errD;

  // Next-state, counter and output decode of the next state for every cluster
  always_comb begin
    clkEnD = '0;
    rstD   = '0;
    isoD   = '0;
    pwrOnD = '0;
    busyD  = '0;
    errD   = errQ;
    for (int i = 0; i < NumClusters; i++) begin
      stateNext[i] = state[i];
      cntNext[i]   = cnt[i];
`ifdef CHIMERA_PWR_SEQ_TIMEOUT_EN
      if (err_clr_i[i]) errD[i] = 1'b0;
`endif
      unique case (state[i])
        Off: begin
          if (en_req_i[i]) begin
            stateNext[i] = ClkEn;
            cntNext[i]   = '0;
          end
        end
        ClkEn: begin
          if (cnt[i] != CntMax) cntNext[i] = cnt[i] + CntWidth'(1);
          if (cnt[i] == RstLast) stateNext[i] = Deiso;
        end
        Deiso: begin
          if (!IsolateClusters || !isolated_i[i]) stateNext[i] = On;
        end
        On: begin
          if (!en_req_i[i]) begin
            stateNext[i] = Iso;
            cntNext[i]   = '0;
          end
        end
        Iso: begin
          if (!IsolateClusters || isolated_i[i]) begin
            stateNext[i] = RstOn;
          end else begin
`ifdef CHIMERA_PWR_SEQ_TIMEOUT_EN
            if (cnt[i] != CntMax) cntNext[i] = cnt[i] + CntWidth'(1);
            // Ack never came: flag it and power the cluster down anyway
            if (cnt[i] == TimeoutLast) begin
              stateNext[i] = RstOn;
              errD[i]      = 1'b1;
            end
`endif
          end
        end
        RstOn: stateNext[i] = Off;
        default: stateNext[i] = Off;
      endcase

      clkEnD[i] = (stateNext[i] != Off);
      rstD[i]   = (stateNext[i] == Off) || (stateNext[i] == ClkEn) || (stateNext[i] == RstOn);
      isoD[i]   = IsolateClusters && ((stateNext[i] == Off) || (stateNext[i] == ClkEn) ||
                                      (stateNext[i] == Iso) || (stateNext[i] == RstOn));
      pwrOnD[i] = (stateNext[i] == On);
      busyD[i]  = (stateNext[i] == ClkEn) || (stateNext[i] == Deiso) ||
                  (stateNext[i] == Iso)   || (stateNext[i] == RstOn);
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumClusters; i++) begin
        state[i] <= Off;
        cnt[i]   <= '0;
      end
      clkEnQ <= '0;
      rstQ   <= '1;
      isoQ   <= {NumClusters{IsolateClusters}};
      pwrOnQ <= '0;
      busyQ  <= '0;
      errQ   <= '0;
    end else begin
      for (int i = 0; i < NumClusters; i++) begin
        state[i] <= stateNext[i];
        cnt[i]   <= cntNext[i];
      end
      clkEnQ <= clkEnD;
      rstQ   <= rstD;
      isoQ   <= isoD;
      pwrOnQ <= pwrOnD;
      busyQ  <= busyD;
      errQ   <= errD;
    end
  end

  assign clk_en_o      = clkEnQ;
  assign cluster_rst_o = rstQ;
  assign isolate_o     = isoQ;
  assign pwr_on_o      = pwrOnQ;
  assign busy_o        = busyQ;
`ifdef CHIMERA_PWR_SEQ_TIMEOUT_EN
  assign err_o = errQ;
`else
  logic unusedErr;
  assign unusedErr = ^{errQ, err_clr_i};
  assign err_o     = '0;
`endif

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Scoreboard bench: phase-level reference model per cluster, checked on two instances (isolation on/off).
module tb_chimera_cluster_pwr_seq;

  localparam int unsigned N = 5;
  localparam int unsigned R = 4;
  localparam int unsigned T = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] en, clr, ack;

  logic [N-1:0] clkEnA, rstA, isoA, pwrA, busyA, errA;
  logic [N-1:0] clkEnB, rstB, isoB, pwrB, busyB, errB;

  chimera_cluster_pwr_seq #(.NumClusters(N), .IsolateClusters(1'b1), .RstCycles(R), .TimeoutCycles(T)) dutIso (
    .clk_i(clk), .rst_i(rst), .en_req_i(en), .err_clr_i(clr), .isolated_i(ack),
    .clk_en_o(clkEnA), .cluster_rst_o(rstA), .isolate_o(isoA), .pwr_on_o(pwrA), .busy_o(busyA), .err_o(errA));

  chimera_cluster_pwr_seq #(.NumClusters(N), .IsolateClusters(1'b0), .RstCycles(R), .TimeoutCycles(T)) dutNoIso (
    .clk_i(clk), .rst_i(rst), .en_req_i(en), .err_clr_i(clr), .isolated_i(ack),
    .clk_en_o(clkEnB), .cluster_rst_o(rstB), .isolate_o(isoB), .pwr_on_o(pwrB), .busy_o(busyB), .err_o(errB));

  typedef struct packed {
    logic [N-1:0] clkEn, rst, iso, pwrOn, busy, err;
  } exp_t;

  typedef enum int {PDown, PRamp, PWake, PUp, PQuiet, PReset} phase_t;

  phase_t ph     [2][N];
  int     left   [2][N];
  int     waited [2][N];
  logic   errM   [2][N];
  exp_t   expQ0[$];
  exp_t   expQ1[$];
  int     total = 0;
  int     bad   = 0;

  // Advance the model one clock using the inputs the DUT will sample at the next edge
  task automatic modelStep(input int m);
    bit isoOn = (m == 0);
    for (int i = 0; i < N; i++) begin
      bit fire = 1'b0;
      if (rst) begin
        ph[m][i]   = PDown;
        errM[m][i] = 1'b0;
        continue;
      end
      case (ph[m][i])
        PDown:  if (en[i]) begin ph[m][i] = PRamp; left[m][i] = R; end
        PRamp:  begin left[m][i]--; if (left[m][i] == 0) ph[m][i] = PWake; end
        PWake:  if (!isoOn || !ack[i]) ph[m][i] = PUp;
        PUp:    if (!en[i]) begin ph[m][i] = PQuiet; waited[m][i] = 0; end
        PQuiet: begin
          if (!isoOn || ack[i]) ph[m][i] = PReset;
`ifdef CHIMERA_PWR_SEQ_TIMEOUT_EN
          else begin
            waited[m][i]++;
            if (waited[m][i] == T) begin ph[m][i] = PReset; fire = 1'b1; end
          end
`endif
        end
        default: ph[m][i] = PDown;
      endcase
      if (fire) errM[m][i] = 1'b1;
      else if (clr[i]) errM[m][i] = 1'b0;
    end
  endtask

  function automatic exp_t modelOut(input int m);
    exp_t e;
    bit isoOn = (m == 0);
    e = '0;
    for (int i = 0; i < N; i++) begin
      phase_t p = ph[m][i];
      e.clkEn[i] = (p != PDown);
      e.rst[i]   = (p inside {PDown, PRamp, PReset});
      e.iso[i]   = isoOn && (p inside {PDown, PRamp, PQuiet, PReset});
      e.pwrOn[i] = (p == PUp);
      e.busy[i]  = (p inside {PRamp, PWake, PQuiet, PReset});
`ifdef CHIMERA_PWR_SEQ_TIMEOUT_EN
      e.err[i]   = errM[m][i];
`else
      e.err[i]   = 1'b0;
`endif
    end
    return e;
  endfunction

  task automatic driveAndPredict(input logic r, input logic [N-1:0] e, input logic [N-1:0] a, input logic [N-1:0] c);
    rst = r; en = e; ack = a; clr = c;
    modelStep(0);
    modelStep(1);
    expQ0.push_back(modelOut(0));
    expQ1.push_back(modelOut(1));
  endtask

  task automatic cycle(input logic r, input logic [N-1:0] e, input logic [N-1:0] a, input logic [N-1:0] c);
    @(negedge clk);
    driveAndPredict(r, e, a, c);
  endtask

  task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, req);
    end
  endtask

  // Monitor: every cycle the DUTs present outputs; compare against the oldest prediction
  initial begin
    exp_t x;
    #1;
    forever begin
      @(negedge clk);
      if (expQ0.size() > 0) begin
        x = expQ0.pop_front();
        cmp("iso.clk_en", clkEnA, x.clkEn); cmp("iso.cluster_rst", rstA, x.rst);
        cmp("iso.isolate", isoA, x.iso);    cmp("iso.pwr_on", pwrA, x.pwrOn);
        cmp("iso.busy", busyA, x.busy);     cmp("iso.err", errA, x.err);
      end
      if (expQ1.size() > 0) begin
        x = expQ1.pop_front();
        cmp("noiso.clk_en", clkEnB, x.clkEn); cmp("noiso.cluster_rst", rstB, x.rst);
        cmp("noiso.isolate", isoB, x.iso);    cmp("noiso.pwr_on", pwrB, x.pwrOn);
        cmp("noiso.busy", busyB, x.busy);     cmp("noiso.err", errB, x.err);
      end
    end
  end

  initial begin
    logic [N-1:0] e, a, c;
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < N; i++) begin
        ph[m][i] = PDown; left[m][i] = 0; waited[m][i] = 0; errM[m][i] = 1'b0;
      end
    driveAndPredict(1'b1, '0, '1, '0);
    cycle(1'b1, '0, '1, '0);

    // Power-up of cluster 0 with ack dropping two cycles into de-isolation
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, '1, '0);
    for (int k = 0; k < R + 2; k++) cycle(1'b0, 5'b00001, '1, '0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 5'b00001, 5'b11110, '0);
    // Power-down with ack three cycles after isolation starts
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, 5'b11110, '0);
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, '1, '0);
    // Single-cycle request glitch on cluster 1, ack idles low so power-down waits
    cycle(1'b0, 5'b00010, 5'b11101, '0);
    for (int k = 0; k < R + 6; k++) cycle(1'b0, '0, 5'b11101, '0);
    for (int k = 0; k < T + 4; k++) cycle(1'b0, '0, 5'b11101, '0);
    cycle(1'b0, '0, 5'b11101, 5'b00010);
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, '1, '0);
    // Reset mid-ramp, then all clusters restart together
    cycle(1'b0, '1, '1, '0);
    cycle(1'b0, '1, '1, '0);
    cycle(1'b1, '1, '1, '0);
    for (int k = 0; k < R + 4; k++) cycle(1'b0, '1, '0, '0);
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, '0, '0);
    cycle(1'b1, '0, '0, '0);
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, '1, '0);

    // Randomized traffic: sticky levels with occasional toggles, pulses and resets
    e = '0; a = '1;
    for (int k = 0; k < 4000; k++) begin
      c = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0) e[i] = ~e[i];
        if ($urandom_range(0, 3) == 0)  a[i] = ~a[i];
        if ($urandom_range(0, 15) == 0) c[i] = 1'b1;
      end
      cycle(($urandom_range(0, 299) == 0), e, a, c);
    end

    @(negedge clk);
    #1;
    total++;
    if (expQ0.size() != 0 || expQ1.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", expQ0.size(), expQ1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
